dual_slope_ctrl: RTL and testbench

DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

---
 rtl/dual_slope_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer: auto-zero, fixed integrate, timed de-integrate, result handshake.
// Define DUAL_SLOPE_BIPOLAR_EN to pick the reference polarity from the comparator at integrate end.
module dual_slope_ctrl #(
  parameter logic [15:0] T_AZ        = 16'd100,
  parameter logic [15:0] T_INT       = 16'd1000,
  parameter logic [15:0] T_DEINT_MAX = 16'd2000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        cmp_i,
  output logic        cnt_en_o,
  output logic        cnt_clear_o,
  output logic [15:0] cnt_limit_o,
  input  logic        cnt_busy_i,
  input  logic        cnt_done_i,
  input  logic [15:0] cnt_count_i,
  output logic [1:0]  sw_sel_o,
  output logic        busy_o,
  output logic [15:0] result_o,
  output logic        result_valid_o,
  input  logic        result_ready_i,
  output logic        overrange_o,
  output logic        sign_o
);

  localparam int unsigned CntW = 16;

  localparam logic [1:0] SwShort = 2'b00;
  localparam logic [1:0] SwVin   = 2'b01;
  localparam logic [1:0] SwVrefP = 2'b10;
  localparam logic [1:0] SwVrefN = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AZ     = 3'd1,
    INT    = 3'd2,
    DEINT  = 3'd3,
    RESULT = 3'd4
  } state_e;

  state_e            state_q;
  logic              first_q;
  logic              cnt_en_q;
  logic              cnt_clear_q;
  logic [CntW-1:0]   cnt_limit_q;
  logic [1:0]        sw_sel_q;
  logic              busy_q;
  logic [CntW-1:0]   result_q;
  logic              result_valid_q;
  logic              overrange_q;

  // Comparator level that means "integrator back at zero" during de-integrate.
  logic              term_lvl_c;
  logic              cmp_hit_c;
  logic [1:0]        deint_sw_d;

`ifdef DUAL_SLOPE_BIPOLAR_EN
  logic              sign_q;
  logic              sign_d;

  assign sign_d     = ~cmp_i;
  assign deint_sw_d = cmp_i ? SwVrefP : SwVrefN;
  assign term_lvl_c = sign_q;
  assign sign_o     = sign_q;
`else
  assign deint_sw_d = SwVrefP;
  assign term_lvl_c = 1'b0;
  assign sign_o     = 1'b0;
`endif

  // Counter may flag done in the same cycle the comparator trips; the comparator wins.
  assign cmp_hit_c = (cmp_i == term_lvl_c) && (cnt_busy_i || cnt_done_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      first_q        <= 1'b0;
      cnt_en_q       <= 1'b0;
      cnt_clear_q    <= 1'b0;
      cnt_limit_q    <= '0;
      sw_sel_q       <= SwShort;
      busy_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrange_q    <= 1'b0;
`ifdef DUAL_SLOPE_BIPOLAR_EN
      sign_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          cnt_en_q    <= 1'b0;
          cnt_clear_q <= 1'b0;
          if (start_i) begin
            state_q     <= AZ;
            first_q     <= 1'b1;
            cnt_clear_q <= 1'b1;
            cnt_limit_q <= T_AZ;
            sw_sel_q    <= SwShort;
            busy_q      <= 1'b1;
          end
        end

        AZ: begin
          if (first_q) begin
            first_q     <= 1'b0;
            cnt_clear_q <= 1'b0;
            cnt_en_q    <= 1'b1;
          end else if (cnt_done_i) begin
            state_q     <= INT;
            first_q     <= 1'b1;
            cnt_clear_q <= 1'b1;
            cnt_en_q    <= 1'b0;
            cnt_limit_q <= T_INT;
            sw_sel_q    <= SwVin;
          end
        end

        INT: begin
          if (first_q) begin
            first_q     <= 1'b0;
            cnt_clear_q <= 1'b0;
            cnt_en_q    <= 1'b1;
          end else if (cnt_done_i) begin
            state_q     <= DEINT;
            first_q     <= 1'b1;
            cnt_clear_q <= 1'b1;
            cnt_en_q    <= 1'b0;
            cnt_limit_q <= T_DEINT_MAX;
            sw_sel_q    <= deint_sw_d;
`ifdef DUAL_SLOPE_BIPOLAR_EN
            sign_q      <= sign_d;
`endif
          end
        end

        DEINT: begin
          if (first_q) begin
            first_q     <= 1'b0;
            cnt_clear_q <= 1'b0;
            cnt_en_q    <= 1'b1;
          end else if (cmp_hit_c || cnt_done_i) begin
            state_q        <= RESULT;
            cnt_clear_q    <= 1'b1;
            cnt_en_q       <= 1'b0;
            sw_sel_q       <= SwShort;
            result_valid_q <= 1'b1;
            result_q       <= cmp_hit_c ? cnt_count_i : 16'hFFFF;
            overrange_q    <= ~cmp_hit_c;
          end
        end

        RESULT: begin
          cnt_clear_q <= 1'b0;
          cnt_en_q    <= 1'b0;
          if (result_valid_q && result_ready_i) begin
            state_q        <= IDLE;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
          end
        end

        default: begin
          state_q  <= IDLE;
          first_q  <= 1'b0;
          cnt_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en_o       = cnt_en_q;
  assign cnt_clear_o    = cnt_clear_q;
  assign cnt_limit_o    = cnt_limit_q;
  assign sw_sel_o       = sw_sel_q;
  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_valid_o = result_valid_q;
  assign overrange_o    = overrange_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl with a behavioural up-counter and a result scoreboard.
module tb_dual_slope_ctrl;

  localparam logic [15:0] TAz  = 16'd4;
  localparam logic [15:0] TInt = 16'd10;
  localparam logic [15:0] TDm  = 16'd20;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        cmp_i;
  logic        cnt_en_o, cnt_clear_o;
  logic [15:0] cnt_limit_o;
  logic        cnt_busy, cnt_done;
  logic [15:0] cnt_count;
  logic [1:0]  sw_sel_o;
  logic        busy_o;
  logic [15:0] result_o;
  logic        result_valid_o;
  logic        result_ready_i = 1'b0;
  logic        overrange_o, sign_o;

  logic [15:0] fall_at = 16'hFFFF;
  logic        cmp_base = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        ovr;
    logic        sgn;
  } exp_t;

  exp_t sb[$];

  dual_slope_ctrl #(.T_AZ(TAz), .T_INT(TInt), .T_DEINT_MAX(TDm)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cmp_i(cmp_i),
    .cnt_en_o(cnt_en_o), .cnt_clear_o(cnt_clear_o), .cnt_limit_o(cnt_limit_o),
    .cnt_busy_i(cnt_busy), .cnt_done_i(cnt_done), .cnt_count_i(cnt_count),
    .sw_sel_o(sw_sel_o), .busy_o(busy_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .overrange_o(overrange_o), .sign_o(sign_o)
  );

  always #5 clk_i = ~clk_i;

  // Counter: clear wins; counts while enabled until reaching the limit, busy held until clear.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_count <= '0;
      cnt_busy  <= 1'b0;
      cnt_done  <= 1'b0;
    end else if (cnt_clear_o) begin
      cnt_count <= '0;
      cnt_busy  <= 1'b0;
      cnt_done  <= 1'b0;
    end else if (cnt_en_o && !cnt_done) begin
      cnt_count <= cnt_count + 16'd1;
      cnt_busy  <= 1'b1;
      cnt_done  <= ((cnt_count + 16'd1) == cnt_limit_o);
    end
  end

  // Integrator model: comparator flips once the de-integrate count reaches fall_at.
  always_comb begin
    cmp_i = cmp_base;
    if (sw_sel_o[1] && cnt_en_o && (cnt_count >= fall_at)) cmp_i = ~cmp_base;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_sw(input logic [1:0] v, input int budget);
    int n = 0;
    while (sw_sel_o !== v && n < budget) begin
      cyc();
      n++;
    end
    if (sw_sel_o !== v) check("timeout_sw_sel", 32'(sw_sel_o), 32'(v));
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (result_valid_o !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    if (result_valid_o !== 1'b1) check("timeout_valid", 32'(result_valid_o), 32'd1);
  endtask

  task automatic pop_check(output exp_t e);
    e = '0;
    if (sb.size() == 0) check("sb_empty", 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      check("result", 32'(result_o), 32'(e.res));
      check("overrange", 32'(overrange_o), 32'(e.ovr));
      check("sign", 32'(sign_o), 32'(e.sgn));
    end
  endtask

  task automatic release_result();
    result_ready_i = 1'b1;
    cyc();
    result_ready_i = 1'b0;
    check("valid_drop", 32'(result_valid_o), 32'd0);
    check("busy_drop", 32'(busy_o), 32'd0);
  endtask

  task automatic start_conv(input logic [15:0] k, input logic base, input exp_t e);
    fall_at  = k;
    cmp_base = base;
    sb.push_back(e);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    #2;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_sw", 32'(sw_sel_o), 32'd0);
    check("rst_limit", 32'(cnt_limit_o), 32'd0);
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_flags", {28'd0, cnt_en_o, cnt_clear_o, result_valid_o, overrange_o}, 32'd0);
    cyc();
    rst_i = 1'b0;
    repeat (4) cyc();
    check("idle_no_start", 32'(busy_o), 32'd0);

    // Normal conversion: comparator trips after 7 de-integrate counts.
    start_conv(16'd7, 1'b1, '{res: 16'd7, ovr: 1'b0, sgn: 1'b0});
    check("az_busy", 32'(busy_o), 32'd1);
    check("az_clear", {30'd0, cnt_clear_o, cnt_en_o}, 32'd2);
    check("az_limit", 32'(cnt_limit_o), 32'(TAz));
    check("az_sw", 32'(sw_sel_o), 32'd0);
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    check("az_run", {30'd0, cnt_clear_o, cnt_en_o}, 32'd1);
    wait_sw(2'b01, 20);
    check("int_clear", {30'd0, cnt_clear_o, cnt_en_o}, 32'd2);
    check("int_limit", 32'(cnt_limit_o), 32'(TInt));
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_sw(2'b10, 30);
    check("deint_limit", 32'(cnt_limit_o), 32'(TDm));
    check("deint_clear", {30'd0, cnt_clear_o, cnt_en_o}, 32'd2);
    wait_valid(40);
    check("res_clear", {30'd0, cnt_clear_o, cnt_en_o}, 32'd2);
    check("res_sw", 32'(sw_sel_o), 32'd0);
    check("res_busy", 32'(busy_o), 32'd1);
    pop_check(e);
    start_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      start_i = 1'b0;
      check("hold_valid", 32'(result_valid_o), 32'd1);
      check("hold_result", 32'(result_o), 32'(e.res));
    end
    check("hold_counter_idle", {30'd0, cnt_clear_o, cnt_en_o}, 32'd0);
    release_result();
    repeat (5) cyc();
    check("no_second_conv", 32'(busy_o), 32'd0);

    // Comparator never trips: de-integrate times out.
    start_conv(16'hFFFF, 1'b1, '{res: 16'hFFFF, ovr: 1'b1, sgn: 1'b0});
    wait_valid(80);
    pop_check(e);
    release_result();

    // Comparator trips exactly when the counter reports done.
    start_conv(TDm, 1'b1, '{res: TDm, ovr: 1'b0, sgn: 1'b0});
    wait_valid(80);
    pop_check(e);
    release_result();

    // Asynchronous reset during integrate.
    fall_at = 16'd3;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_sw(2'b01, 20);
    cyc();
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy", 32'(busy_o), 32'd0);
    check("arst_sw", 32'(sw_sel_o), 32'd0);
    check("arst_limit", 32'(cnt_limit_o), 32'd0);
    check("arst_result", 32'(result_o), 32'd0);
    check("arst_flags", {28'd0, cnt_en_o, cnt_clear_o, result_valid_o, overrange_o}, 32'd0);
    cyc();
    rst_i = 1'b0;
    repeat (30) cyc();
    check("post_rst_idle", 32'(busy_o), 32'd0);
    check("post_rst_valid", 32'(result_valid_o), 32'd0);

`ifdef DUAL_SLOPE_BIPOLAR_EN
    // Negative input: comparator low at integrate end, rises after 5 counts.
    start_conv(16'd5, 1'b0, '{res: 16'd5, ovr: 1'b0, sgn: 1'b1});
    wait_sw(2'b11, 40);
    check("bip_sign", 32'(sign_o), 32'd1);
    wait_valid(40);
    pop_check(e);
    release_result();
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
